// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared frame geometry, default widths and grant encoding for the VRAM arbiter
package vram_pkg;

  localparam int VRAM_WIDTH  = 640;
  localparam int VRAM_HEIGHT = 480;
  localparam int VRAM_DEPTH  = VRAM_WIDTH * VRAM_HEIGHT;

  localparam int DEFAULT_DATA_WIDTH = 3;
  localparam int DEFAULT_ADDR_WIDTH = 19;

  // One memory operation per cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } gnt_e;

  // True when a pixel address lies inside the visible frame.
  function automatic logic inVram(input logic [31:0] addr);
    return addr < 32'(VRAM_DEPTH);
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - CPU write buffer for the VRAM arbiter
//
// Purpose: small FIFO holding {address, pixel} entries until the arbiter
// finds a free memory slot. Full/empty come from registered flags so the
// CPU side sees a clean full indication at the start of each cycle.
//
// Ports:
//   Clock, Reset          clock, asynchronous active-low reset
//   iPush, iPushData      write an entry (ignored while full)
//   iPop                  drop the head entry (ignored while empty)
//   oHeadData             current head entry
//   oFull, oEmpty         registered occupancy flags
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oHeadData,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer tells a full buffer from an empty one.
  logic [PTR_W-1:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic             doPush, doPop;

  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;

  assign wrPtrNext = doPush ? wrPtr + PTR_W'(1) : wrPtr;
  assign rdPtrNext = doPop  ? rdPtr + PTR_W'(1) : rdPtr;

  assign oHeadData = mem[rdPtr[PW-1:0]];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oFull  <= 1'b0;
      oEmpty <= 1'b1;
    end else begin
      wrPtr  <= wrPtrNext;
      rdPtr  <= rdPtrNext;
      oFull  <= (wrPtrNext[PW] != rdPtrNext[PW]) &&
                (wrPtrNext[PW-1:0] == rdPtrNext[PW-1:0]);
      oEmpty <= (wrPtrNext == rdPtrNext);
    end
  end

  always_ff @(posedge Clock) begin
    if (doPush) begin
      mem[wrPtr[PW-1:0]] <= iPushData;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between display reads and buffered CPU writes
//
// Purpose: each cycle grants the RAM to the display (read), to the head of
// the CPU write buffer (write), or to nobody. The display wins by default.
// Optional build macro VRAM_ARB_STARVE_GUARD_EN adds a starvation guard that
// forces a write after STARVE_MAX read grants that left buffered writes waiting.
//
// Ports:
//   Clock, Reset                      clock, asynchronous active-low reset
//   iCpuWrReq/iCpuWrAddr/iCpuWrData   CPU pixel write (one-cycle pulse)
//   oCpuWrAck                         write accepted this cycle (combinational)
//   oCpuFull                          write buffer full (registered)
//   iDispRdReq/iDispRdAddr            display read, held until granted
//   oDispGnt                          display read granted this cycle (combinational)
//   oDispRdData/oDispRdValid          read pixel, three cycles after the grant
//   oMemWriteEnable/oMemAddress/oMemDataIn  registered RAM controls
//   iMemDataOut                       RAM read data, one-cycle latency
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuWrReq,
  input  logic [ADDR_WIDTH-1:0] iCpuWrAddr,
  input  logic [DATA_WIDTH-1:0] iCpuWrData,
  output logic                  oCpuWrAck,
  output logic                  oCpuFull,
  input  logic                  iDispRdReq,
  input  logic [ADDR_WIDTH-1:0] iDispRdAddr,
  output logic                  oDispGnt,
  output logic [DATA_WIDTH-1:0] oDispRdData,
  output logic                  oDispRdValid,
  output logic                  oMemWriteEnable,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemDataIn,
  input  logic [DATA_WIDTH-1:0] iMemDataOut
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (STARVE_MAX < 1) begin : gBadStarve
    $error("STARVE_MAX must be at least 1");
  end

  logic                  fifoFull, fifoEmpty;
  logic [ENTRY_W-1:0]    headEntry;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;
  logic                  push;
  logic                  forceWrite;
  gnt_e                  grant;

  // Read pipeline: issued to the RAM, then waiting for RAM data.
  logic rdIssue, rdIssueOob, rdPend, rdPendOob;

  assign {headAddr, headData} = headEntry;

  // Acceptance uses the full flag from the start of the cycle, so a
  // same-cycle pop never frees a slot for a push.
  assign push      = Reset && iCpuWrReq && !fifoFull;
  assign oCpuWrAck = push;
  assign oCpuFull  = fifoFull;
  assign oDispGnt  = (grant == GNT_READ);

  // Empty is a start-of-cycle flag, so a fresh push can never be popped in
  // the same cycle.
  always_comb begin
    grant = GNT_NONE;
    if (!Reset) begin
      grant = GNT_NONE;
    end else if (forceWrite) begin
      grant = GNT_WRITE;
    end else if (iDispRdReq) begin
      grant = GNT_READ;
    end else if (!fifoEmpty) begin
      grant = GNT_WRITE;
    end
  end

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) uWrFifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPush     (push),
    .iPushData ({iCpuWrAddr, iCpuWrData}),
    .iPop      (grant == GNT_WRITE),
    .oHeadData (headEntry),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty)
  );

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starveCnt;

  assign forceWrite = (starveCnt == STARVE_W'(STARVE_MAX)) && !fifoEmpty;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      starveCnt <= '0;
    end else if (grant == GNT_WRITE) begin
      starveCnt <= '0;
    end else if (grant == GNT_READ && !fifoEmpty &&
                 starveCnt != STARVE_W'(STARVE_MAX)) begin
      starveCnt <= starveCnt + STARVE_W'(1);
    end
  end
`else
  assign forceWrite = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oMemWriteEnable <= 1'b0;
      oMemAddress     <= '0;
      oMemDataIn      <= '0;
      rdIssue         <= 1'b0;
      rdIssueOob      <= 1'b0;
      rdPend          <= 1'b0;
      rdPendOob       <= 1'b0;
      oDispRdValid    <= 1'b0;
      oDispRdData     <= '0;
    end else begin
      oMemWriteEnable <= 1'b0;
      unique case (grant)
        GNT_READ: oMemAddress <= iDispRdAddr;
        GNT_WRITE: begin
          // Off-screen writes are consumed silently; the bus keeps its address.
          if (inVram(32'(headAddr))) begin
            oMemWriteEnable <= 1'b1;
            oMemAddress     <= headAddr;
            oMemDataIn      <= headData;
          end
        end
        default: ;
      endcase

      rdIssue      <= (grant == GNT_READ);
      rdIssueOob   <= !inVram(32'(iDispRdAddr));
      rdPend       <= rdIssue;
      rdPendOob    <= rdIssueOob;
      oDispRdValid <= rdPend;
      if (rdPend) begin
        oDispRdData <= rdPendOob ? '0 : iMemDataOut;
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 3: pixel width (R,G,B bits).
REQ-002 Parameter ADDR_WIDTH, default 19: video memory address width.
REQ-003 Parameter FIFO_DEPTH, default 4: CPU write buffer entries; power of two, at least 2.
REQ-004 Parameter STARVE_MAX, default 8: consecutive denied-write cycles before a forced write.
REQ-005 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 iCpuWrReq  in  1  CPU pixel write request, one-cycle pulse per pixel.
REQ-008 iCpuWrAddr  in  ADDR_WIDTH  CPU write address.
REQ-009 iCpuWrData  in  DATA_WIDTH  CPU write pixel.
REQ-010 oCpuWrAck  out  1  combinational; write accepted into the FIFO this cycle.
REQ-011 oCpuFull  out  1  registered; FIFO full.
REQ-012 iDispRdReq  in  1  display read request; held until granted.
REQ-013 iDispRdAddr  in  ADDR_WIDTH  display read address; stable while the request is held.
REQ-014 oDispGnt  out  1  combinational; display read granted this cycle.
REQ-015 oDispRdData  out  DATA_WIDTH  registered read pixel.
REQ-016 oDispRdValid  out  1  registered; oDispRdData valid.
REQ-017 oMemWriteEnable, oMemAddress, oMemDataIn  out  1/ADDR_WIDTH/DATA_WIDTH  registered single-port RAM controls.
REQ-018 iMemDataOut  in  DATA_WIDTH  RAM read data; synchronous read, 1-cycle latency.

Function
REQ-019 The block SHALL grant one memory operation per cycle: NONE, READ or WRITE.
REQ-020 Priority SHALL be: display read first, then write of the FIFO head when the FIFO is not empty, otherwise NONE.
REQ-021 A CPU request SHALL be accepted (oCpuWrAck=1) only when the FIFO is not full at the start of the cycle; a rejected request SHALL be lost, with no retry.
REQ-022 A push to an empty FIFO SHALL NOT be popped in the same cycle; there is no bypass path.
REQ-023 When the FIFO is full, a push SHALL be rejected even if a pop occurs in the same cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-025 The grant decided in cycle C SHALL appear on oMem* in cycle C+1; NONE SHALL drive oMemWriteEnable=0 and hold the address.
REQ-026 For a display grant in cycle C, oDispRdValid SHALL be 1 in cycle C+3 only, with oDispRdData = iMemDataOut sampled in cycle C+2.
REQ-027 A CPU write address >= 307200 SHALL be acknowledged and popped, with no memory write issued.
REQ-028 A display address >= 307200 SHALL be granted and SHALL return 0 in cycle C+3.
REQ-029 A granted read and the pop of its write SHALL never occur in the same cycle.

Reset
REQ-030 While Reset=0 the block SHALL hold: FIFO empty, oCpuFull=0, oMemWriteEnable=0, oMemAddress=0, oMemDataIn=0, oDispRdData=0, oDispRdValid=0, starve counter=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight reads (no oDispRdValid after release) and buffered writes.
REQ-032 The first grant after reset release SHALL occur in the first full cycle with Reset=1.

Configuration
REQ-033 With VRAM_ARB_STARVE_GUARD_EN defined, a saturating counter SHALL count cycles in which the FIFO is non-empty and a read is granted.
REQ-034 When the counter reaches STARVE_MAX, the next cycle SHALL grant WRITE with oDispGnt=0 (display holds its request), and the counter SHALL clear on any write grant.
REQ-035 Without VRAM_ARB_STARVE_GUARD_EN, strict display priority SHALL apply and no counter SHALL exist.

Structure
REQ-036 Package vram_pkg SHALL hold VRAM_WIDTH=640, VRAM_HEIGHT=480, VRAM_DEPTH=307200, the default DATA_WIDTH and ADDR_WIDTH, and the grant encoding GNT_NONE/GNT_READ/GNT_WRITE.
REQ-037 The write buffer SHALL be the sub-module vram_wr_fifo (parameterised depth and width, push/pop/full/empty).

Verification
REQ-038 Reset release, then a CPU write to 0x00100 of data 3'b101, then a read of 0x00100 → oMemWriteEnable=1 two cycles after ack; read returns 3'b101 with oDispRdValid 3 cycles after oDispGnt.
REQ-039 Five CPU writes on consecutive cycles with iDispRdReq held high and guard disabled → four acks, fifth rejected, oCpuFull=1, zero memory writes.
REQ-040 Same stimulus with VRAM_ARB_STARVE_GUARD_EN → forced write after 8 read grants, oDispGnt=0 in that cycle, reads resume the next cycle.
REQ-041 CPU write to 307200 and a display read of 307200 → write acked with no oMemWriteEnable; read data 0.
REQ-042 Reset pulled low one cycle after a display grant → oDispRdValid stays 0; FIFO empty after release.
